// File: rtl/piso_stream_pkg.sv
// Shared types and helpers for the piso_stream serialiser.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  localparam int PISO_WIDTH_DEF = 8;

  // Index of the shift-register bit driven onto the serial line for a given bit order.
  function automatic int out_tap(input int width, input bit lsb_first);
    return lsb_first ? 0 : width - 1;
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Word intake and serial output bundle of piso_stream.
interface piso_stream_if
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_WIDTH_DEF
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             out_bit;
  logic             out_valid;
  logic             done;

  // Producer / link controller side.
  modport master (
    output in_data, in_valid, shift_en,
    input  in_ready, out_bit, out_valid, done
  );

  // Serialiser side.
  modport slave (
    input  in_data, in_valid, shift_en,
    output in_ready, out_bit, out_valid, done
  );

endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready intake, selectable bit order
// and an external shift strobe for baud pacing. Back-to-back words stream gaplessly.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_WIDTH_DEF,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  piso_stream_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam int                OUT_TAP  = out_tap(WIDTH, LSB_FIRST);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sr_shift;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // Shift register advanced by one bit toward the output tap, zero filled.
  always_comb begin
    if (LSB_FIRST) sr_shift = {1'b0, sr_q[WIDTH-1:1]};
    else           sr_shift = {sr_q[WIDTH-2:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers: shift register, bit counter and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  // Next state: load on accept, advance on strobe, chain or retire on the last bit.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // From idle a word is taken regardless of the strobe.
        if (bus.in_valid) begin
          sr_d    = bus.in_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (cnt_q == CNT_LAST) begin
            done_d = 1'b1;
            if (bus.in_valid) begin
              sr_d  = bus.in_data;
              cnt_d = '0;
            end else begin
              sr_d    = sr_shift;
              cnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; mid-word the intake opens only on the strobe that consumes the last bit.
  always_comb begin
    bus.out_valid = 1'b0;
    bus.in_ready  = 1'b1;
    if (state_q == SHIFT) begin
      bus.out_valid = 1'b1;
      bus.in_ready  = bus.shift_en && (cnt_q == CNT_LAST);
    end
  end

  assign bus.out_bit = sr_q[OUT_TAP];
  assign bus.done    = done_q;

endmodule

// File: tb/tb_piso_stream.sv
module tb_piso_stream;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tot = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  piso_stream_if #(.WIDTH(8)) if8 ();
  piso_stream_if #(.WIDTH(4)) if4 ();

  piso_stream #(.WIDTH(8), .LSB_FIRST(1'b0)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  piso_stream #(.WIDTH(4), .LSB_FIRST(1'b1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  seq_a5;
  logic [3:0]  seq_lsb;
  logic [15:0] seq_gap;
  logic [7:0]  seq_81;
  logic [7:0]  seq_c3;

  initial begin
    seq_a5  = 8'b1010_0101;           // 0xA5 MSB first
    seq_lsb = 4'b1011;                // 4'b1101 LSB first, in transmit order
    seq_gap = 16'b1111_0000_0000_1111; // 0xF0 then 0x0F, MSB first
    seq_81  = 8'b1000_0001;
    seq_c3  = 8'b1100_0011;

    rst_n        = 1'b0;
    if8.in_data  = '0;
    if8.in_valid = 1'b0;
    if8.shift_en = 1'b1;
    if4.in_data  = '0;
    if4.in_valid = 1'b0;
    if4.shift_en = 1'b1;

    // ---- reset state ----
    #3;
    chk("rst_out_valid8", 32'(if8.out_valid), 32'd0);
    chk("rst_out_bit8",   32'(if8.out_bit),   32'd0);
    chk("rst_done8",      32'(if8.done),      32'd0);
    chk("rst_out_valid4", 32'(if4.out_valid), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready8", 32'(if8.in_ready), 32'd1);
    chk("rel_in_ready4", 32'(if4.in_ready), 32'd1);
    tick();

    // ---- MSB first 0xA5 ----
    if8.in_data  = 8'hA5;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("a5_bit",   32'(if8.out_bit),   32'(seq_a5[7-i]));
      chk("a5_valid", 32'(if8.out_valid), 32'd1);
      chk("a5_done",  32'(if8.done),      32'd0);
      tick();
    end
    chk("a5_done_pulse", 32'(if8.done),      32'd1);
    chk("a5_idle",       32'(if8.out_valid), 32'd0);
    tick();
    chk("a5_done_low",   32'(if8.done),      32'd0);

    // ---- LSB first 4'b1101 ----
    if4.in_data  = 4'b1101;
    if4.in_valid = 1'b1;
    tick();
    if4.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lsb_bit",   32'(if4.out_bit),   32'(seq_lsb[3-i]));
      chk("lsb_valid", 32'(if4.out_valid), 32'd1);
      tick();
    end
    chk("lsb_done", 32'(if4.done),      32'd1);
    chk("lsb_idle", 32'(if4.out_valid), 32'd0);
    tick();

    // ---- gapless 0xF0 then 0x0F ----
    if8.in_data  = 8'hF0;
    if8.in_valid = 1'b1;
    tick();
    if8.in_data  = 8'h0F;
    for (int i = 0; i < 16; i++) begin
      chk("gap_bit",   32'(if8.out_bit),   32'(seq_gap[15-i]));
      chk("gap_valid", 32'(if8.out_valid), 32'd1);
      chk("gap_done",  32'(if8.done),      32'(i == 8));
      if (i < 8) chk("gap_ready", 32'(if8.in_ready), 32'(i == 7));
      tick();
      if (i == 7) if8.in_valid = 1'b0;
    end
    chk("gap_done2", 32'(if8.done),      32'd1);
    chk("gap_idle",  32'(if8.out_valid), 32'd0);
    tick();

    // ---- paced: strobe every 3rd cycle, 0x81 ----
    if8.in_data  = 8'h81;
    if8.in_valid = 1'b1;
    if8.shift_en = 1'b0;
    tick();
    if8.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int p = 0; p < 3; p++) begin
        if8.shift_en = (p == 2);
        if (b == 3) begin
          if8.in_valid = 1'b1;
          if8.in_data  = 8'hFF;
        end else begin
          if8.in_valid = 1'b0;
        end
        #1;
        chk("pace_bit",   32'(if8.out_bit),   32'(seq_81[7-b]));
        chk("pace_valid", 32'(if8.out_valid), 32'd1);
        if (b == 3) chk("pace_ready_mid", 32'(if8.in_ready), 32'd0);
        if (b == 7 && p == 2) chk("pace_ready_last", 32'(if8.in_ready), 32'd1);
        tick();
      end
    end
    if8.shift_en = 1'b1;
    chk("pace_done", 32'(if8.done),      32'd1);
    chk("pace_idle", 32'(if8.out_valid), 32'd0);
    tick();

    // ---- stall in IDLE, then accept with strobe low ----
    if8.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk("stall_valid", 32'(if8.out_valid), 32'd0);
      chk("stall_bit",   32'(if8.out_bit),   32'd0);
      tick();
    end
    if8.in_data  = 8'hC3;
    if8.in_valid = 1'b1;
    if8.shift_en = 1'b0;
    tick();
    if8.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("hold_bit",   32'(if8.out_bit),   32'd1);
      chk("hold_valid", 32'(if8.out_valid), 32'd1);
      tick();
    end
    if8.shift_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("c3_bit", 32'(if8.out_bit), 32'(seq_c3[7-i]));
      tick();
    end
    chk("c3_done", 32'(if8.done), 32'd1);
    tick();

    // ---- asynchronous reset mid-word ----
    if8.in_data  = 8'hFF;
    if8.in_valid = 1'b1;
    tick();
    if8.in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_bit",   32'(if8.out_bit),   32'd1);
    chk("pre_rst_valid", 32'(if8.out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_bit",   32'(if8.out_bit),   32'd0);
    chk("async_valid", 32'(if8.out_valid), 32'd0);
    chk("async_done",  32'(if8.done),      32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(if8.in_ready), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("post_rst_done",  32'(if8.done),      32'd0);
      chk("post_rst_valid", 32'(if8.out_valid), 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out shifter with valid/ready word intake, configurable bit order and an external shift-enable for baud pacing. It serialises WIDTH-bit words onto a single-bit line for downstream serial links and supports gapless back-to-back words. It is the successor to the team's fixed 4-bit PISO.

## Interface
- WIDTH, 8, word width in bits; legal range 2 and up.
- LSB_FIRST, 0, 0 = MSB transmitted first, 1 = LSB transmitted first.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  parallel word; sampled only on accept.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block can accept a word this cycle.
- shift_en  in  1  bit-advance strobe; tie to 1 for one bit per clk.
- out_bit  out  1  serial data.
- out_valid  out  1  out_bit carries a payload bit.
- done  out  1  one-cycle pulse after the last bit of a word is consumed.

## Operation
- Reset is asynchronous and active-low: rst_n=0 immediately forces the following, regardless of clk:
  - state = IDLE
  - shift register = 0
  - bit counter = 0
  - out_bit = 0, out_valid = 0, done = 0
  - in_ready = 1 once rst_n is released.
- Reset mid-word aborts the word; no done pulse is generated.
- States:
  - IDLE: out_valid = 0; in_ready = 1.
  - SHIFT: out_valid = 1; in_ready = shift_en && (cnt == WIDTH-1), a combinational path from shift_en.
- Accept = in_valid && in_ready.
  - Loads in_data into the shift register, sets cnt = 0 and moves to (or stays in) SHIFT.
- Accept timing from IDLE: the word is accepted regardless of shift_en. The first bit is presented from the next cycle.
- Output selection:
  - LSB_FIRST = 0: out_bit = sr[WIDTH-1]; the register shifts left with a 0 fill.
  - LSB_FIRST = 1: out_bit = sr[0]; the register shifts right with a 0 fill.
- out_bit is a direct register output with no combinational path from the inputs.
- SHIFT with shift_en = 0: hold sr, cnt and out_bit.
- SHIFT with shift_en = 1 and cnt < WIDTH-1: shift once and increment cnt.
- SHIFT with shift_en = 1 and cnt == WIDTH-1: the last bit is consumed and done is registered to 1.
  - If in_valid is also 1: load the new word, set cnt = 0 and stay in SHIFT (gapless).
  - Otherwise: shift (sr becomes all 0) and go to IDLE.
- In IDLE, out_bit is 0 by construction (the register is all zeros).
- The counter is $clog2(WIDTH) bits wide. It never exceeds WIDTH-1 and never wraps.

## Timing
- Latency: accept at edge k gives the first bit valid in cycle k+1.
- With shift_en tied to 1, a word occupies exactly WIDTH cycles.
- Back-to-back words form a continuous stream with out_valid held at 1.
- With shift_en = 1 one cycle in N, each bit is held for N cycles.
- done is high for exactly one cycle, the cycle after the edge that consumes bit WIDTH-1. It fires for every word, including gapless ones.
- Minimum idle-to-idle turnaround: WIDTH+1 cycles. The extra cycle is IDLE before the next accept when a word is not chained.

## Structure
- Package piso_pkg holds:
  - the state typedef (IDLE, SHIFT)
  - the default WIDTH constant
  - a bit-order localparam helper.
- Single module, no sub-modules. The counter and shift register are inline; a separate counter module is not warranted.

## Test plan
- Reset: drive rst_n=0 mid-word with WIDTH=8 -> out_bit, out_valid and done go to 0 immediately, with no clk edge needed. After release, in_ready = 1.
- MSB-first (WIDTH=8, LSB_FIRST=0, shift_en=1): send 0xA5 -> out_bit = 1,0,1,0,0,1,0,1 on cycles k+1..k+8. done pulses at k+9. out_valid returns to 0 at k+9.
- LSB-first (WIDTH=4, LSB_FIRST=1): send 4'b1101 -> out_bit = 1,0,1,1.
- Gapless (WIDTH=8): send 0xF0 and hold 0x0F valid. in_ready rises only in the cycle bit 7 is consumed -> 16 contiguous bits 11110000 00001111, out_valid never drops, and done pulses twice, 8 cycles apart.
- Paced: shift_en high every 3rd cycle, send 0x81 (WIDTH=8) -> each bit is held 3 cycles. in_valid asserted mid-word is ignored until the final strobe.
- Stall in IDLE: in_valid=0 for 20 cycles -> out_valid=0 and out_bit=0 throughout. Then an accept with shift_en=0 still loads the word, and the first bit holds until the first strobe.
